// File: rtl/slt_serial_16bit.sv
// slt_serial_16bit: bit-serial 16-bit magnitude comparator.
// Scans the captured operands MSB first, one bit per clock, and reports
// less-than / equal / greater-than as 16'h0001 / 16'h0000 words.
// SIGNED=1 selects a two's-complement compare (sign bit decision inverted).
// Optional feature macro: SLT_EARLY_EXIT_EN -- when defined the scan ends on
// the first differing bit; otherwise every scan covers all 16 bits.
module slt_serial_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [15:0] RS,
  input  logic [15:0] RT,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] LT_O,
  output logic [15:0] EQ_O,
  output logic [15:0] GT_O
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Decision latched at the most significant differing bit.
  localparam logic [1:0] D_NONE = 2'd0;
  localparam logic [1:0] D_LT   = 2'd1;
  localparam logic [1:0] D_GT   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] rs_q, rs_d;
  logic [15:0] rt_q, rt_d;
  logic        signed_q, signed_d;
  logic [1:0]  dec_q, dec_d;
  logic [15:0] lt_q, lt_d;
  logic [15:0] eq_q, eq_d;
  logic [15:0] gt_q, gt_d;

  logic        bit_rs;
  logic        bit_rt;
  logic        bit_differ;
  logic        bit_is_lt;
  logic [1:0]  bit_dec;
  logic [1:0]  final_dec;
  logic        last_bit;
  logic        terminate;

  // Per-bit decision for the bit currently under the scan index.
  always_comb begin
    bit_rs     = rs_q[idx_q];
    bit_rt     = rt_q[idx_q];
    bit_differ = bit_rs ^ bit_rt;
    // In a signed compare the sign bit carries negative weight, so a 1 in RS
    // at bit 15 means RS is the smaller operand.
    bit_is_lt  = (~bit_rs & bit_rt) ^ (signed_q & (idx_q == 4'd15));
    bit_dec    = bit_differ ? (bit_is_lt ? D_LT : D_GT) : D_NONE;
    // An earlier (more significant) decision always wins.
    final_dec  = (dec_q != D_NONE) ? dec_q : bit_dec;
    last_bit   = (idx_q == 4'd0);
`ifdef SLT_EARLY_EXIT_EN
    terminate  = last_bit | bit_differ;
`else
    terminate  = last_bit;
`endif
  end

  // Next-state logic: operand capture, scan stepping and result update.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    signed_d = signed_q;
    dec_d    = dec_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d  = S_SCAN;
          idx_d    = 4'd15;
          rs_d     = RS;
          rt_d     = RT;
          signed_d = SIGNED;
          dec_d    = D_NONE;
          lt_d     = 16'h0000;
          eq_d     = 16'h0000;
          gt_d     = 16'h0000;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SCAN: begin
        // START is deliberately ignored while scanning.
        dec_d = final_dec;
        idx_d = idx_q - 4'd1;
        if (terminate) begin
          state_d = S_DONE;
          idx_d   = 4'd15;
          lt_d    = {15'd0, final_dec == D_LT};
          eq_d    = {15'd0, final_dec == D_NONE};
          gt_d    = {15'd0, final_dec == D_GT};
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd15;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd15;
      rs_q     <= 16'h0000;
      rt_q     <= 16'h0000;
      signed_q <= 1'b0;
      dec_q    <= D_NONE;
      lt_q     <= 16'h0000;
      eq_q     <= 16'h0000;
      gt_q     <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      signed_q <= signed_d;
      dec_q    <= dec_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
    end
  end

  // Outputs are direct decodes of registered state.
  always_comb begin
    BUSY = (state_q == S_SCAN);
    DONE = (state_q == S_DONE);
    LT_O = lt_q;
    EQ_O = eq_q;
    GT_O = gt_q;
  end

endmodule

// File: tb/tb_slt_serial_16bit.sv
// tb_slt_serial_16bit: bench for slt_serial_16bit.
// A transaction-level model (arithmetic compare + latency from the position
// of the most significant differing bit) predicts BUSY/DONE/outputs; a
// compare process checks them every cycle. Directed cases pin known values.
module tb_slt_serial_16bit;

`ifdef SLT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int R_NONE = 0;
  localparam int R_LT   = 1;
  localparam int R_EQ   = 2;
  localparam int R_GT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [15:0] RS = 16'h0000;
  logic [15:0] RT = 16'h0000;
  logic        BUSY;
  logic        DONE;
  logic [15:0] LT_O;
  logic [15:0] EQ_O;
  logic [15:0] GT_O;

  int n_checks = 0;
  int n_fail   = 0;

  slt_serial_16bit dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .SIGNED(SIGNED),
    .RS    (RS),
    .RT    (RT),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .LT_O  (LT_O),
    .EQ_O  (EQ_O),
    .GT_O  (GT_O)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic compare.
  function automatic int ref_result(input bit s, input logic [15:0] a, input logic [15:0] b);
    if (a == b) return R_EQ;
    if (s) return ($signed(a) < $signed(b)) ? R_LT : R_GT;
    return (a < b) ? R_LT : R_GT;
  endfunction

  // Reference: edges from acceptance to the terminating edge.
  function automatic int ref_latency(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    x = a ^ b;
    if (!EARLY || x == 16'h0000) return 16;
    for (int k = 15; k >= 0; k--)
      if (x[k]) return 16 - k;
    return 16;
  endfunction

  // ---------------- transaction-level model ----------------
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_left = 0;
  int m_pend = R_NONE;
  int m_res  = R_NONE;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_pend = R_NONE;
      m_res  = R_NONE;
    end else if (START && !m_busy) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_res  = R_NONE;
      m_pend = ref_result(SIGNED, RS, RT);
      m_left = ref_latency(RS, RT);
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  function automatic logic [63:0] exp_vec(input bit b, input bit d, input int r);
    return {14'd0, b, d, 15'd0, r == R_LT, 15'd0, r == R_EQ, 15'd0, r == R_GT};
  endfunction

  function automatic logic [63:0] act_vec();
    return {14'd0, BUSY, DONE, LT_O, EQ_O, GT_O};
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cycle", act_vec(), exp_vec(m_busy, m_done, m_res));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (DONE) begin
        lat = n;
        break;
      end
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_cmp(input string name, input bit s, input logic [15:0] a,
                         input logic [15:0] b, input int exp_res, input int exp_lat);
    @(negedge clk);
    START = 1'b1; SIGNED = s; RS = a; RT = b;
    @(negedge clk);
    START = 1'b0; RS = 16'($urandom); RT = 16'($urandom); SIGNED = ~s;
    wait_done(name, exp_lat);
    check({name, "_res"}, {LT_O, EQ_O, GT_O}, exp_vec(1'b0, 1'b0, exp_res));
  endtask

  initial begin
    bit saw_done;
    bit rst_now;

    // Pin the model with hand-computed values.
    check("model_lt_u", 64'(ref_result(1'b0, 16'h0003, 16'h0005)), 64'(R_LT));
    check("model_lt_s", 64'(ref_result(1'b1, 16'hFFFF, 16'h0001)), 64'(R_LT));
    check("model_gt_u", 64'(ref_result(1'b0, 16'hFFFF, 16'h0001)), 64'(R_GT));
    check("model_lat",  64'(ref_latency(16'h0003, 16'h0005)), EARLY ? 64'd14 : 64'd16);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_state", act_vec(), 64'd0);
    rst = 1'b0;

    run_cmp("r029", 1'b0, 16'h0003, 16'h0005, R_LT, EARLY ? 14 : 16);
    run_cmp("r030s", 1'b1, 16'hFFFF, 16'h0001, R_LT, EARLY ? 1 : 16);
    run_cmp("r030u", 1'b0, 16'hFFFF, 16'h0001, R_GT, EARLY ? 1 : 16);
    run_cmp("r031", 1'b1, 16'h8000, 16'h8000, R_EQ, 16);
    run_cmp("sgn_pos_neg", 1'b1, 16'h0001, 16'h8000, R_GT, EARLY ? 1 : 16);
    run_cmp("lsb_diff", 1'b0, 16'h1235, 16'h1234, R_GT, 16);

    // Second START during SCAN is ignored.
    @(negedge clk);
    START = 1'b1; SIGNED = 1'b0; RS = 16'h0010; RT = 16'h0001;
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    START = 1'b1; RS = 16'h0000; RT = 16'hFFFF;
    @(negedge clk);
    START = 1'b0;
    wait_done("r032", EARLY ? 10 : 14);
    check("r032_res", {LT_O, EQ_O, GT_O}, exp_vec(1'b0, 1'b0, R_GT));

    // Reset in the middle of a scan.
    @(negedge clk);
    START = 1'b1; SIGNED = 1'b0; RS = 16'h00FF; RT = 16'h00F0;
    @(negedge clk);
    START = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("r033_abort", act_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (DONE) saw_done = 1'b1;
    end
    check("r033_no_done", 64'(saw_done), 64'd0);
    run_cmp("r033_eq", 1'b0, 16'h1234, 16'h1234, R_EQ, 16);

    // START accepted in the DONE cycle: no IDLE gap, outputs cleared.
    @(negedge clk);
    START = 1'b1; SIGNED = 1'b0; RS = 16'h0003; RT = 16'h0005;
    @(negedge clk);
    START = 1'b0;
    wait_done("r034_a", EARLY ? 14 : 16);
    START = 1'b1; RS = 16'h0001; RT = 16'h0002;
    @(negedge clk);
    START = 1'b0;
    check("r034_chain", act_vec(), exp_vec(1'b1, 1'b0, R_NONE));
    wait_done("r034_b", EARLY ? 15 : 16);
    check("r034_res", {LT_O, EQ_O, GT_O}, exp_vec(1'b0, 1'b0, R_LT));

    // Randomized traffic checked cycle-by-cycle against the model.
    rst_now = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      START  = ($urandom_range(3) == 0);
      SIGNED = 1'($urandom);
      RS     = 16'($urandom);
      case ($urandom_range(3))
        0: RT = RS;
        1: RT = RS ^ (16'h0001 << $urandom_range(15));
        2: RT = {RS[15:8], 8'($urandom)};
        default: RT = 16'($urandom);
      endcase
      rst_now = ($urandom_range(199) == 0);
      if (rst_now) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    START = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
